mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: width of the Mem word address.
REQ-002 Parameter DATA_W, default 32: width of BUS and data ports.
REQ-003 Parameter RD_LAT, default 1, legal range 1..7: cycles Memread is held before BUS is sampled.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 p0_req  in  1  port 0 (instruction fetch) request; held until p0_ack.
REQ-007 p0_we  in  2  port 0 write-size code; 2'b00 means read, nonzero means write, passed unchanged to Memwrite.
REQ-008 p0_addr  in  ADDR_W  port 0 address.
REQ-009 p0_wdata  in  DATA_W  port 0 write data.
REQ-010 p0_ack  out  1  one-cycle pulse marking port 0 transaction completion.
REQ-011 p0_rdata  out  DATA_W  port 0 read data, valid while p0_ack=1.
REQ-012 p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: port 1 (data access), identical widths and meanings to port 0.
REQ-013 Memread  out  1  Mem read strobe.
REQ-014 Memwrite  out  2  Mem write-size code; 2'b00 means no write.
REQ-015 Addrin  out  ADDR_W  Mem address.
REQ-016 BUS  inout  DATA_W  shared Mem data bus; driven by the block only during write access, otherwise high-Z.

Function
REQ-017 FSM states: IDLE, RD_ACC, WR_ACC, DONE; all Mem-side outputs are registered.
REQ-018 IDLE: if any req=1, pick a winner via round-robin, latch its we/addr/wdata and port id, and go to RD_ACC (we=0) or WR_ACC (we!=0); otherwise stay in IDLE.
REQ-019 Round-robin: priority goes to the port not granted last; after reset port 0 has priority; with a single request pending, that port wins regardless of the pointer.
REQ-020 RD_ACC: Memread=1 and Addrin=latched address for exactly RD_LAT cycles, counted by a 3-bit counter; BUS is sampled into the read-data register on the edge ending the last RD_ACC cycle; next state is DONE.
REQ-021 WR_ACC: lasts one cycle with Memwrite=latched code, Addrin=latched address and BUS driven with latched wdata; Memread=0; next state is DONE.
REQ-022 DONE: lasts one cycle; the granted port's ack=1; for a read, its rdata equals the sampled BUS value; Mem outputs are idle (Memread=0, Memwrite=0, BUS high-Z); next state is IDLE.
REQ-023 Latency from req sampled in IDLE to ack: RD_LAT+1 cycles for a read, 2 cycles for a write.
REQ-024 The non-granted port's ack stays 0; its rdata holds its previous value.
REQ-025 Dropping req after the grant does not abort the transaction; it completes and ack still pulses.
REQ-026 A req still high in the IDLE cycle after ack starts a new transaction, subject to round-robin.
REQ-027 BUS is never driven while Memread=1.
REQ-028 Addrin holds its last value when idle; Memread and Memwrite are 0 in IDLE and DONE.

Reset
REQ-029 rst=1 immediately forces: state IDLE, Memread=0, Memwrite=2'b00, Addrin=0, BUS high-Z, p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, counter 0, priority pointer to port 0.
REQ-030 Reset during any access aborts it with no ack; after rst deasserts, operation resumes from IDLE on the next rising edge.

Structure
REQ-031 Package zpc_mem_pkg holds ADDR_W/DATA_W defaults, the FSM state encoding and the constant WE_NONE=2'b00.
REQ-032 The two-way round-robin selector with its pointer is sub-module mem_rr_arb2 (inputs req[1:0] and update strobe; output grant[1:0]).

Verification
REQ-033 Reset: assert rst mid-cycle -> Memread=0, Memwrite=0, Addrin=0, BUS=Z, acks=0 without waiting for a clock edge.
REQ-034 RD_LAT=1, Mem word 1=32'hDEADBEEF, p0 read addr 12'h001 -> Memread=1 with Addrin=12'h001 in cycle 1; p0_ack=1 with p0_rdata=32'hDEADBEEF in cycle 2.
REQ-035 p1 write we=2'b01, addr 12'h010, data 32'h12345678 -> one cycle with Memwrite=2'b01 and BUS=32'h12345678, then p1_ack; a later p0 read of 12'h010 returns 32'h12345678.
REQ-036 Both ports request continuously after reset -> grant order 0,1,0,1, no ack overlap, BUS never driven while Memread=1.
REQ-037 rst pulsed during WR_ACC -> Memwrite=0 and BUS=Z at once, no ack; the held request is served after release.
REQ-038 RD_LAT=3, p1 read -> Memread high for 3 cycles, p1_ack in cycle 4 with the correct data.

Source files
------------

// File: rtl/zpc_mem_pkg.sv
// Shared constants and FSM encoding for the two-port Mem arbiter.
// Port-side and Mem-side logic both import this package.
package zpc_mem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] WE_NONE = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_ACC = 2'd1,
    ST_WR_ACC = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin selector. The pointer names the port that has
// priority on a tie; it moves to the other port whenever a grant is taken.
module mem_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (upd_i && (grant_o != 2'b00)) begin
      ptr_q <= grant_o[0];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto a single
// Mem interface with a shared tri-state data bus.
module mem_arbiter
  import zpc_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [1:0]        p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic [1:0]        p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              Memread,
  output logic [1:0]        Memwrite,
  output logic [ADDR_W-1:0] Addrin,
  inout  wire  [DATA_W-1:0] BUS
);

  localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

  state_e            state_q;
  logic              port_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              memread_q;
  logic [1:0]        memwrite_q;
  logic              bus_oe_q;
  logic              ack0_q, ack1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [1:0]        grant;
  logic              start;
  logic              sel_d;
  logic [1:0]        we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  assign start = (state_q == ST_IDLE) && (p0_req || p1_req);

  mem_rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_i   ({p1_req, p0_req}),
    .upd_i   (start),
    .grant_o (grant)
  );

  always_comb begin
    sel_d   = grant[1];
    we_d    = sel_d ? p1_we    : p0_we;
    addr_d  = sel_d ? p1_addr  : p0_addr;
    wdata_d = sel_d ? p1_wdata : p0_wdata;
  end

  // Mem strobes are set on entry to an access state and cleared on exit,
  // so every Mem-side output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      port_q     <= 1'b0;
      cnt_q      <= 3'd0;
      wdata_q    <= '0;
      addr_q     <= '0;
      memread_q  <= 1'b0;
      memwrite_q <= WE_NONE;
      bus_oe_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (start) begin
            port_q  <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= 3'd0;
            if (we_d == WE_NONE) begin
              state_q   <= ST_RD_ACC;
              memread_q <= 1'b1;
            end else begin
              state_q    <= ST_WR_ACC;
              memwrite_q <= we_d;
              bus_oe_q   <= 1'b1;
            end
          end
        end
        ST_RD_ACC: begin
          if (cnt_q == LAST_CNT) begin
            if (port_q) rdata1_q <= BUS;
            else        rdata0_q <= BUS;
            ack0_q    <= ~port_q;
            ack1_q    <= port_q;
            memread_q <= 1'b0;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_WR_ACC: begin
          memwrite_q <= WE_NONE;
          bus_oe_q   <= 1'b0;
          ack0_q     <= ~port_q;
          ack1_q     <= port_q;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUS      = bus_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign Memread  = memread_q;
  assign Memwrite = memwrite_q;
  assign Addrin   = addr_q;
  assign p0_ack   = ack0_q;
  assign p1_ack   = ack1_q;
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at RD_LAT=1 with a small
// Mem model, one at RD_LAT=3 for the long-read case.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        p0_req, p1_req, p0_ack, p1_ack;
  logic [1:0]  p0_we, p1_we;
  logic [11:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic        rd_a;
  logic [1:0]  wr_a;
  logic [11:0] addr_a;
  tri0  [31:0] bus_a;

  logic        b_p0_req, b_p1_req, b_p0_ack, b_p1_ack;
  logic [1:0]  b_p0_we, b_p1_we;
  logic [11:0] b_p0_addr, b_p1_addr;
  logic [31:0] b_p0_wdata, b_p1_wdata, b_p0_rdata, b_p1_rdata;
  logic        rd_b;
  logic [1:0]  wr_b;
  logic [11:0] addr_b;
  tri0  [31:0] bus_b;

  int nvec = 0;
  int nerr = 0;

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .Memread(rd_a), .Memwrite(wr_a), .Addrin(addr_a), .BUS(bus_a)
  );

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .Memread(rd_b), .Memwrite(wr_b), .Addrin(addr_b), .BUS(bus_b)
  );

  // Mem model A: 256 words, pattern A50000xx except word 1.
  logic [31:0] mema [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mema[i] <= 32'hA5000000 + 32'(i);
      mema[1] <= 32'hDEADBEEF;
    end else if (wr_a != 2'b00) begin
      mema[addr_a[7:0]] <= bus_a;
    end
  end
  assign bus_a = rd_a ? mema[addr_a[7:0]] : 32'hzzzzzzzz;
  assign bus_b = rd_b ? (32'hA5000000 + {20'h0, addr_b}) : 32'hzzzzzzzz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int n, ovl;
  int seq [0:3];

  initial begin
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    b_p0_req = 0; b_p0_we = 0; b_p0_addr = 0; b_p0_wdata = 0;
    b_p1_req = 0; b_p1_we = 0; b_p1_addr = 0; b_p1_wdata = 0;

    repeat (3) @(negedge clk);
    chk("rst_memread", 64'(rd_a), 64'd0);
    chk("rst_memwrite", 64'(wr_a), 64'd0);
    chk("rst_addrin", 64'(addr_a), 64'd0);
    chk("rst_bus", 64'(bus_a), 64'd0);
    chk("rst_acks", 64'({p0_ack, p1_ack}), 64'd0);
    chk("rst_rdata", 64'({p0_rdata, p1_rdata}), 64'd0);
    rst = 0;

    // p0 read of word 1; req dropped right after the grant
    @(negedge clk); p0_req = 1; p0_we = 2'b00; p0_addr = 12'h001;
    @(negedge clk);
    chk("rd_memread", 64'(rd_a), 64'd1);
    chk("rd_addrin", 64'(addr_a), 64'h001);
    chk("rd_bus", 64'(bus_a), 64'hDEADBEEF);
    chk("rd_ack_early", 64'(p0_ack), 64'd0);
    p0_req = 0;
    @(negedge clk);
    chk("rd_ack", 64'(p0_ack), 64'd1);
    chk("rd_data", 64'(p0_rdata), 64'hDEADBEEF);
    chk("rd_p1_ack", 64'(p1_ack), 64'd0);
    chk("rd_done_memread", 64'(rd_a), 64'd0);
    @(negedge clk);
    chk("rd_ack_pulse", 64'(p0_ack), 64'd0);
    chk("idle_addr_hold", 64'(addr_a), 64'h001);

    // p1 write, then p0 reads it back
    p1_req = 1; p1_we = 2'b01; p1_addr = 12'h010; p1_wdata = 32'h12345678;
    @(negedge clk);
    chk("wr_memwrite", 64'(wr_a), 64'd1);
    chk("wr_bus", 64'(bus_a), 64'h12345678);
    chk("wr_memread", 64'(rd_a), 64'd0);
    chk("wr_addrin", 64'(addr_a), 64'h010);
    p1_req = 0;
    @(negedge clk);
    chk("wr_ack", 64'(p1_ack), 64'd1);
    chk("wr_done_bus", 64'(bus_a), 64'd0);
    chk("wr_done_memwrite", 64'(wr_a), 64'd0);
    chk("wr_p0_ack", 64'(p0_ack), 64'd0);
    chk("wr_p0_rdata_hold", 64'(p0_rdata), 64'hDEADBEEF);
    @(negedge clk);
    p0_req = 1; p0_addr = 12'h010;
    @(negedge clk); p0_req = 0;
    @(negedge clk);
    chk("rb_ack", 64'(p0_ack), 64'd1);
    chk("rb_data", 64'(p0_rdata), 64'h12345678);
    @(negedge clk);

    // both ports requesting continuously from reset
    rst = 1; @(negedge clk); rst = 0;
    p0_req = 1; p0_we = 2'b00; p0_addr = 12'h002;
    p1_req = 1; p1_we = 2'b10; p1_addr = 12'h020; p1_wdata = 32'hCAFEF00D;
    n = 0; ovl = 0;
    repeat (13) begin
      @(negedge clk);
      if (p0_ack && p1_ack) ovl++;
      else if (p0_ack) begin if (n < 4) seq[n] = 0; n++; end
      else if (p1_ack) begin if (n < 4) seq[n] = 1; n++; end
      if (rd_a) chk("rr_bus_vs_mem", 64'(bus_a), 64'(mema[addr_a[7:0]]));
    end
    p0_req = 0; p1_req = 0;
    repeat (3) @(negedge clk);
    chk("rr_count", 64'(n), 64'd4);
    chk("rr_overlap", 64'(ovl), 64'd0);
    chk("rr_g0", 64'(seq[0]), 64'd0);
    chk("rr_g1", 64'(seq[1]), 64'd1);
    chk("rr_g2", 64'(seq[2]), 64'd0);
    chk("rr_g3", 64'(seq[3]), 64'd1);
    chk("rr_wr_mem", 64'(mema[8'h20]), 64'hCAFEF00D);

    // reset pulsed mid-cycle during a write access
    p1_req = 1; p1_we = 2'b11; p1_addr = 12'h030; p1_wdata = 32'h55AA55AA;
    @(negedge clk);
    chk("rw_memwrite", 64'(wr_a), 64'd3);
    #2 rst = 1;
    #1;
    chk("rw_async_memwrite", 64'(wr_a), 64'd0);
    chk("rw_async_bus", 64'(bus_a), 64'd0);
    chk("rw_async_memread", 64'(rd_a), 64'd0);
    chk("rw_async_addrin", 64'(addr_a), 64'd0);
    chk("rw_async_acks", 64'({p0_ack, p1_ack}), 64'd0);
    chk("rw_async_rdata", 64'(p0_rdata), 64'd0);
    @(negedge clk);
    chk("rw_no_ack", 64'(p1_ack), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("rw_retry_memwrite", 64'(wr_a), 64'd3);
    chk("rw_retry_bus", 64'(bus_a), 64'h55AA55AA);
    p1_req = 0;
    @(negedge clk);
    chk("rw_retry_ack", 64'(p1_ack), 64'd1);
    @(negedge clk);

    // reset pulsed mid-cycle during a read access
    p0_req = 1; p0_we = 2'b00; p0_addr = 12'h005;
    @(negedge clk);
    chk("rr_rst_memread", 64'(rd_a), 64'd1);
    #2 rst = 1;
    #1;
    chk("rr_rst_async_memread", 64'(rd_a), 64'd0);
    chk("rr_rst_async_addrin", 64'(addr_a), 64'd0);
    p0_req = 0;
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("rr_rst_no_ack", 64'(p0_ack), 64'd0);

    // RD_LAT=3 read on port 1
    b_p1_req = 1; b_p1_we = 2'b00; b_p1_addr = 12'h007;
    @(negedge clk);
    chk("lat3_c1_memread", 64'(rd_b), 64'd1);
    chk("lat3_c1_bus", 64'(bus_b), 64'hA5000007);
    b_p1_req = 0;
    @(negedge clk);
    chk("lat3_c2_memread", 64'(rd_b), 64'd1);
    chk("lat3_c2_ack", 64'(b_p1_ack), 64'd0);
    @(negedge clk);
    chk("lat3_c3_memread", 64'(rd_b), 64'd1);
    chk("lat3_c3_ack", 64'(b_p1_ack), 64'd0);
    @(negedge clk);
    chk("lat3_c4_ack", 64'(b_p1_ack), 64'd1);
    chk("lat3_c4_memread", 64'(rd_b), 64'd0);
    chk("lat3_c4_data", 64'(b_p1_rdata), 64'hA5000007);
    chk("lat3_p0_ack", 64'(b_p0_ack), 64'd0);
    @(negedge clk);
    chk("lat3_ack_pulse", 64'(b_p1_ack), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
